// File: rtl/apb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : apb_pkg
// Purpose  : Shared state encoding, width helpers and the ID default for the
//            APB register-file completer.
// Revision : 1.0 - initial release
// ============================================================================
package apb_pkg;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } apb_state_t;

    localparam logic [31:0] C_ID_DEFAULT = 32'hA0B1_0001;
    localparam int          C_CNT_W      = 4;

    // Byte-offset bits stripped from paddr to form a word index.
    function automatic int apb_lsb(input int dw);
        return $clog2(dw / 8);
    endfunction

    function automatic int apb_idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/apb_wait_counter.sv
`default_nettype none
// ============================================================================
// Module   : apb_wait_counter
// Purpose  : 4-bit load/decrement counter with zero flag for APB wait states.
// Revision : 1.0 - initial release
// ============================================================================
module apb_wait_counter
    import apb_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic [C_CNT_W-1:0] i_load_val,
    input  logic               i_dec,
    output logic               o_zero
);

    logic [C_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - C_CNT_W'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/apb_regfile_slave.sv
`default_nettype none
// ============================================================================
// Module   : apb_regfile_slave
// Purpose  : APB3 completer with NUM_REGS registers (index 0 = read-only ID),
//            programmable wait states and alignment/range checking.
//            Define APB_SLVERR_EN to report bad accesses on pslverr.
// Revision : 1.0 - initial release
// ============================================================================
module apb_regfile_slave
    import apb_pkg::*;
#(
    parameter int                    DATAWIDTH   = 32,
    parameter int                    ADDRWIDTH   = 8,
    parameter int                    NUM_REGS    = 16,
    parameter int                    WAIT_STATES = 0,
    parameter logic [DATAWIDTH-1:0]  ID_VALUE    = DATAWIDTH'(C_ID_DEFAULT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDRWIDTH-1:0]  paddr,
    input  logic [DATAWIDTH-1:0]  pwdata,
    input  logic                  pwrite,
    input  logic                  psel,
    input  logic                  penable,
    output logic [DATAWIDTH-1:0]  prdata,
    output logic                  pready,
    output logic                  pslverr
);

    localparam int              LSB   = apb_lsb(DATAWIDTH);
    localparam int              IDXW  = ADDRWIDTH - LSB;
    localparam int              RIW   = apb_idx_w(NUM_REGS);
    localparam logic [IDXW:0]   C_NUM = (IDXW + 1)'(NUM_REGS);

    apb_state_t             r_state;
    logic [DATAWIDTH-1:0]   r_regs [NUM_REGS];
    logic [RIW-1:0]         r_idx;
    logic                   r_write;
    logic                   r_err;
    logic [DATAWIDTH-1:0]   r_wdata;

    logic [IDXW-1:0]        w_idx;
    logic [RIW-1:0]         w_ridx;
    logic                   w_misalign;
    logic                   w_oor;
    logic                   w_id;
    logic                   w_bad;
    logic [DATAWIDTH-1:0]   w_rdval;
    logic                   w_setup;
    logic                   w_access;
    logic                   w_zero;
    logic                   w_dec;

    assign w_idx      = paddr[ADDRWIDTH-1:LSB];
    assign w_ridx     = w_idx[RIW-1:0];
    assign w_misalign = |paddr[LSB-1:0];
    assign w_oor      = ({1'b0, w_idx} >= C_NUM);
    assign w_id       = (w_idx == '0);
    // The ID word is read-only, so a write to it is treated like any bad access.
    assign w_bad      = w_misalign | w_oor | (pwrite & w_id);
    assign w_rdval    = w_id ? ID_VALUE : r_regs[w_ridx];

    assign w_setup    = (r_state == ST_IDLE) && psel && !penable;
    assign w_access   = (r_state == ST_ACCESS) && psel && penable;
    assign w_dec      = w_access && !w_zero;

    apb_wait_counter u_wait_counter (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_setup),
        .i_load_val (C_CNT_W'(WAIT_STATES)),
        .i_dec      (w_dec),
        .o_zero     (w_zero)
    );

    assign pready = (r_state == ST_ACCESS) && w_zero;

`ifdef APB_SLVERR_EN
    assign pslverr = pready && r_err;
`else
    assign pslverr = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            prdata  <= '0;
            r_idx   <= '0;
            r_write <= 1'b0;
            r_err   <= 1'b0;
            r_wdata <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_setup) begin
                        r_idx   <= w_ridx;
                        r_write <= pwrite;
                        r_err   <= w_bad;
                        r_wdata <= pwdata;
                        prdata  <= (!pwrite && !w_bad) ? w_rdval : '0;
                        r_state <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    // Dropping psel before completion aborts with no side effects.
                    if (!psel) begin
                        prdata  <= '0;
                        r_state <= ST_IDLE;
                    end else if (w_access && w_zero) begin
                        if (r_write && !r_err) begin
                            r_regs[r_idx] <= r_wdata;
                        end
                        prdata  <= '0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
